get_cost_levels: RTL



---
 rtl/get_cost_levels.sv | 126 ++++++++++++
 1 files changed

// File: rtl/get_cost_levels.sv
// Level-cost accumulator: sums x*x or |x| over a captured block of
// signed coefficients, LANES per cycle, saturating at the result width.
module get_cost_levels #(
  parameter int BIT_WIDTH = 16,
  parameter int COEFFS    = 16,
  parameter int BLOCKS    = 8,
  parameter int LANES     = 16,
  parameter int SUM_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               mode,
  input  logic [BIT_WIDTH*COEFFS*BLOCKS-1:0] levels,
  output logic                               busy,
  output logic [SUM_WIDTH-1:0]               sum,
  output logic                               sat,
  output logic                               done
);

  localparam int TOTAL = COEFFS * BLOCKS;
  localparam int N     = TOTAL / LANES;
  localparam int CW    = (N > 1) ? $clog2(N) : 1;
  localparam int LW    = 2 * BIT_WIDTH + $clog2(LANES) + 1;
  localparam int AW    = ((LW > SUM_WIDTH) ? LW : SUM_WIDTH) + 1;
  localparam int CB    = LANES * BIT_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    FIN
  } state_t;

  state_t state, state_nx;

  logic [TOTAL*BIT_WIDTH-1:0] lv_q;
  logic                       mode_q;
  logic [CW-1:0]              idx;
  logic [SUM_WIDTH-1:0]       acc;
  logic                       acc_sat;

  logic                        accept;
  logic                        last;
  logic [CB-1:0]               chunk;
  logic signed [BIT_WIDTH-1:0] x;
  logic signed [BIT_WIDTH:0]   xe;
  logic [BIT_WIDTH:0]          ab;
  logic signed [2*BIT_WIDTH-1:0] sq;
  logic [LW-1:0]               lane_sum;
  logic [AW-1:0]               acc_ext;
  logic                        over;

  assign accept = start && (state != ACC);
  assign last   = (idx == CW'(N - 1));
  assign busy   = (state == ACC);
  assign chunk  = lv_q[idx*CB +: CB];

  // One extra sign bit keeps |-2^(BIT_WIDTH-1)| from wrapping.
  always_comb begin
    lane_sum = '0;
    x        = '0;
    xe       = '0;
    ab       = '0;
    sq       = '0;
    for (int l = 0; l < LANES; l++) begin
      x  = signed'(chunk[l*BIT_WIDTH +: BIT_WIDTH]);
      xe = (BIT_WIDTH+1)'(x);
      ab = (xe < 0) ? unsigned'(-xe) : unsigned'(xe);
      sq = x * x;
      if (mode_q)
        lane_sum = lane_sum + LW'(ab);
      else
        lane_sum = lane_sum + LW'($unsigned(sq));
    end
  end

  assign acc_ext = AW'(acc) + AW'(lane_sum);
  assign over    = acc_sat || (acc_ext > AW'({SUM_WIDTH{1'b1}}));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = ACC;
      ACC:  if (last) state_nx = FIN;
      FIN:  state_nx = start ? ACC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      acc     <= '0;
      acc_sat <= 1'b0;
      sum     <= '0;
      sat     <= 1'b0;
      done    <= 1'b0;
      lv_q    <= '0;
      mode_q  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= (state == FIN);
      if (state == FIN) begin
        sum <= acc;
        sat <= acc_sat;
      end
      if (accept) begin
        lv_q    <= levels;
        mode_q  <= mode;
        idx     <= '0;
        acc     <= '0;
        acc_sat <= 1'b0;
      end else if (state == ACC) begin
        idx <= idx + 1'b1;
        if (over) begin
          acc     <= '1;
          acc_sat <= 1'b1;
        end else begin
          acc <= acc_ext[SUM_WIDTH-1:0];
        end
      end
    end
  end

endmodule
